// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the raw coin sensors, classifies
// each insertion into a one-cycle coin code or reject pulse, flags jams, counts coins.
//
// state     | meaning
// IDLE      | slot empty, waiting for a sensor to rise
// DEBOUNCE  | pattern captured, waiting for it to stay stable long enough
// HELD      | coin decided, waiting for the sensors to clear
// RELEASE   | sensors low, waiting for them to stay low long enough
// JAM       | sensor stuck high past the jam limit
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 64,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sense_a,
  input  logic             sense_b,
  input  logic             accept_en,
  output logic [1:0]       in_code,
  output logic             reject,
  output logic             jam,
  output logic [CNT_W-1:0] coin_count
);

  localparam int TW = $clog2(JAM_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE,
    S_JAM
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    sync1, sync2;
  logic [1:0]    pat;
  logic [1:0]    cap, cap_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic [1:0]    code_nxt;
  logic          rej_nxt;
  logic          jam_nxt;
  logic          count_inc;
  logic          deb_done;
  logic          jam_done;

  // Two-flop synchroniser per sensor line; bit 1 is sensor B, bit 0 is sensor A.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {sense_b, sense_a};
      sync2 <= sync1;
    end
  end

  assign pat      = sync2;
  assign deb_done = (cnt == TW'(DEBOUNCE_CYCLES - 1));
  assign jam_done = (cnt == TW'(JAM_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_RELEASE;
      cnt        <= '0;
      cap        <= 2'b00;
      in_code    <= 2'b00;
      reject     <= 1'b0;
      jam        <= 1'b0;
      coin_count <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cap     <= cap_nxt;
      in_code <= code_nxt;
      reject  <= rej_nxt;
      jam     <= jam_nxt;
      if (count_inc && (coin_count != {CNT_W{1'b1}}))
        coin_count <= coin_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_nxt   = cap;
    code_nxt  = 2'b00;
    rej_nxt   = 1'b0;
    jam_nxt   = jam;
    count_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (pat != 2'b00) begin
          cap_nxt   = pat;
          cnt_nxt   = '0;
          state_nxt = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (pat != cap) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (deb_done) begin
          cnt_nxt   = '0;
          state_nxt = S_HELD;
          // Both sensors at once is an unknown coin and always goes to the return chute.
          if (accept_en && (cap == 2'b01)) begin
            code_nxt  = 2'b01;
            count_inc = 1'b1;
          end else if (accept_en && (cap == 2'b10)) begin
            code_nxt  = 2'b10;
            count_inc = 1'b1;
          end else begin
            rej_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      S_HELD: begin
        if (pat == 2'b00) begin
          cnt_nxt   = '0;
          state_nxt = S_RELEASE;
        end else if (jam_done) begin
          cnt_nxt   = '0;
          jam_nxt   = 1'b1;
          state_nxt = S_JAM;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      S_RELEASE: begin
        if (pat != 2'b00) begin
          cnt_nxt   = '0;
          state_nxt = S_HELD;
        end else if (deb_done) begin
          cnt_nxt   = '0;
          jam_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      S_JAM: begin
        jam_nxt = 1'b1;
        if (pat == 2'b00) begin
          cnt_nxt   = '0;
          state_nxt = S_RELEASE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_RELEASE;
      end
    endcase
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: latency, glitch rejection, classification,
// accept_en sampling, jam handling, reset abort and counter saturation.
module tb_coin_acceptor;

  logic       clk;
  logic       rst;
  logic       sense_a;
  logic       sense_b;
  logic       accept_en;
  logic [1:0] in_code;
  logic       reject;
  logic       jam;
  logic [7:0] coin_count;
  logic [1:0] in_code2;
  logic       reject2;
  logic       jam2;
  logic [1:0] coin_count2;

  int passed = 0;
  int total  = 0;

  int n_a, n_b, n_rej, n_bad, first_idx, jam_rise, jam_fall;

  coin_acceptor dut (
    .clk(clk), .rst(rst), .sense_a(sense_a), .sense_b(sense_b),
    .accept_en(accept_en), .in_code(in_code), .reject(reject),
    .jam(jam), .coin_count(coin_count)
  );

  coin_acceptor #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .sense_a(sense_a), .sense_b(sense_b),
    .accept_en(accept_en), .in_code(in_code2), .reject(reject2),
    .jam(jam2), .coin_count(coin_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Drives one insertion and records what the outputs did. Index k counts negedges
  // after the sensors were raised, so the first sampling edge t0 precedes k=1.
  task automatic run_coin(input logic a, input logic b, input int hold, input int gap,
                          input int en_idx, input logic en_val);
    logic prev_jam;
    n_a = 0; n_b = 0; n_rej = 0; n_bad = 0;
    first_idx = -1; jam_rise = -1; jam_fall = -1;
    prev_jam = jam;
    sense_a = a;
    sense_b = b;
    for (int k = 1; k <= hold + gap; k++) begin
      @(negedge clk);
      if (in_code == 2'b01) n_a++;
      if (in_code == 2'b10) n_b++;
      if (reject) n_rej++;
      if ((in_code == 2'b11) || ((in_code != 2'b00) && reject)) n_bad++;
      if (((in_code != 2'b00) || reject) && (first_idx < 0)) first_idx = k;
      if (jam && !prev_jam) jam_rise = k;
      if (!jam && prev_jam) jam_fall = k;
      prev_jam = jam;
      if (k == hold) begin
        sense_a = 1'b0;
        sense_b = 1'b0;
      end
      if (k == en_idx) accept_en = en_val;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({in_code, reject, jam} !== 4'b0000) $display("FAIL reset_outputs got %b want 0000", {in_code, reject, jam}); else passed++;
    total++; if (coin_count !== 8'd0) $display("FAIL reset_count got %0d want 0", coin_count); else passed++;
    total++; if (coin_count2 !== 2'd0) $display("FAIL reset_count_sat got %0d want 0", coin_count2); else passed++;
    rst = 1'b1;
    repeat (8) @(negedge clk);
    total++; if ({in_code, reject, jam} !== 4'b0000) $display("FAIL idle_outputs got %b want 0000", {in_code, reject, jam}); else passed++;
  endtask

  task automatic test_coin_a();
    run_coin(1'b1, 1'b0, 12, 20, -1, 1'b1);
    total++; if (n_a !== 1) $display("FAIL a_pulse_cycles got %0d want 1", n_a); else passed++;
    total++; if (n_b + n_rej !== 0) $display("FAIL a_other_events got %0d want 0", n_b + n_rej); else passed++;
    total++; if (first_idx !== 7) $display("FAIL a_latency got %0d want 7", first_idx); else passed++;
    total++; if (n_bad !== 0) $display("FAIL a_illegal_out got %0d want 0", n_bad); else passed++;
    total++; if (coin_count !== 8'd1) $display("FAIL a_count got %0d want 1", coin_count); else passed++;
  endtask

  task automatic test_glitch();
    run_coin(1'b0, 1'b1, 2, 15, -1, 1'b1);
    total++; if (n_b + n_a + n_rej !== 0) $display("FAIL glitch2_events got %0d want 0", n_b + n_a + n_rej); else passed++;
    run_coin(1'b0, 1'b1, 3, 15, -1, 1'b1);
    total++; if (n_b + n_a + n_rej !== 0) $display("FAIL glitch3_events got %0d want 0", n_b + n_a + n_rej); else passed++;
    run_coin(1'b0, 1'b1, 4, 15, -1, 1'b1);
    total++; if (n_b + n_a + n_rej !== 0) $display("FAIL glitch4_events got %0d want 0", n_b + n_a + n_rej); else passed++;
    total++; if (coin_count !== 8'd1) $display("FAIL glitch_count got %0d want 1", coin_count); else passed++;
    run_coin(1'b0, 1'b1, 5, 15, -1, 1'b1);
    total++; if (n_b !== 1) $display("FAIL min_pulse_b got %0d want 1", n_b); else passed++;
    total++; if (first_idx !== 7) $display("FAIL min_pulse_latency got %0d want 7", first_idx); else passed++;
    total++; if (coin_count !== 8'd2) $display("FAIL min_pulse_count got %0d want 2", coin_count); else passed++;
  endtask

  task automatic test_both();
    run_coin(1'b1, 1'b1, 10, 20, -1, 1'b1);
    total++; if (n_rej !== 1) $display("FAIL both_reject got %0d want 1", n_rej); else passed++;
    total++; if (n_a + n_b !== 0) $display("FAIL both_code got %0d want 0", n_a + n_b); else passed++;
    total++; if (first_idx !== 7) $display("FAIL both_latency got %0d want 7", first_idx); else passed++;
    total++; if (n_bad !== 0) $display("FAIL both_illegal_out got %0d want 0", n_bad); else passed++;
    total++; if (coin_count !== 8'd2) $display("FAIL both_count got %0d want 2", coin_count); else passed++;
    run_coin(1'b0, 1'b1, 10, 20, -1, 1'b1);
    total++; if (n_b !== 1) $display("FAIL b_pulse got %0d want 1", n_b); else passed++;
    total++; if (coin_count !== 8'd3) $display("FAIL b_count got %0d want 3", coin_count); else passed++;
  endtask

  task automatic test_accept_en();
    accept_en = 1'b0;
    run_coin(1'b1, 1'b0, 12, 20, -1, 1'b0);
    total++; if (n_rej !== 1) $display("FAIL dis_reject got %0d want 1", n_rej); else passed++;
    total++; if (n_a !== 0) $display("FAIL dis_code got %0d want 0", n_a); else passed++;
    total++; if (coin_count !== 8'd3) $display("FAIL dis_count got %0d want 3", coin_count); else passed++;
    accept_en = 1'b0;
    run_coin(1'b1, 1'b0, 20, 20, 12, 1'b1);
    total++; if (n_a !== 0) $display("FAIL late_en_code got %0d want 0", n_a); else passed++;
    total++; if (n_rej !== 1) $display("FAIL late_en_reject got %0d want 1", n_rej); else passed++;
    accept_en = 1'b0;
    run_coin(1'b1, 1'b0, 12, 20, 7, 1'b1);
    total++; if (n_rej !== 1) $display("FAIL post_decision_en got %0d want 1", n_rej); else passed++;
    accept_en = 1'b0;
    run_coin(1'b1, 1'b0, 12, 20, 6, 1'b1);
    total++; if (n_a !== 1) $display("FAIL decision_edge_en got %0d want 1", n_a); else passed++;
    total++; if (coin_count !== 8'd4) $display("FAIL en_count got %0d want 4", coin_count); else passed++;
    accept_en = 1'b1;
  endtask

  task automatic test_jam();
    run_coin(1'b1, 1'b0, 100, 20, -1, 1'b1);
    total++; if (n_a !== 1) $display("FAIL jam_single_code got %0d want 1", n_a); else passed++;
    total++; if (jam_rise !== 71) $display("FAIL jam_rise got %0d want 71", jam_rise); else passed++;
    total++; if (jam_fall !== 107) $display("FAIL jam_fall got %0d want 107", jam_fall); else passed++;
    total++; if (coin_count !== 8'd5) $display("FAIL jam_count got %0d want 5", coin_count); else passed++;
    run_coin(1'b0, 1'b1, 10, 20, -1, 1'b1);
    total++; if (n_b !== 1) $display("FAIL after_jam_code got %0d want 1", n_b); else passed++;
    total++; if (first_idx !== 7) $display("FAIL after_jam_latency got %0d want 7", first_idx); else passed++;
    total++; if (coin_count !== 8'd6) $display("FAIL after_jam_count got %0d want 6", coin_count); else passed++;
  endtask

  task automatic test_reset_abort();
    sense_a = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if ({in_code, reject, jam} !== 4'b0000) $display("FAIL abort_outputs got %b want 0000", {in_code, reject, jam}); else passed++;
    total++; if (coin_count !== 8'd0) $display("FAIL abort_count got %0d want 0", coin_count); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_coin(1'b1, 1'b0, 30, 20, -1, 1'b1);
    total++; if (n_a + n_b + n_rej !== 0) $display("FAIL preset_coin_events got %0d want 0", n_a + n_b + n_rej); else passed++;
    run_coin(1'b1, 1'b0, 10, 20, -1, 1'b1);
    total++; if (n_a !== 1) $display("FAIL post_abort_code got %0d want 1", n_a); else passed++;
    total++; if (first_idx !== 7) $display("FAIL post_abort_latency got %0d want 7", first_idx); else passed++;
    total++; if (coin_count !== 8'd1) $display("FAIL post_abort_count got %0d want 1", coin_count); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      run_coin(1'b1, 1'b0, 8, 15, -1, 1'b1);
      total++; if (coin_count2 !== 2'((i > 3) ? 3 : i)) $display("FAIL sat_count_%0d got %0d want %0d", i, coin_count2, (i > 3) ? 3 : i); else passed++;
      total++; if (coin_count !== 8'(i)) $display("FAIL wide_count_%0d got %0d want %0d", i, coin_count, i); else passed++;
    end
  endtask

  initial begin
    rst = 1'b0;
    sense_a = 1'b0;
    sense_b = 1'b0;
    accept_en = 1'b1;
    test_reset();
    test_coin_a();
    test_glitch();
    test_both();
    test_accept_en();
    test_jam();
    test_reset_abort();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage directly upstream of vending_machine. Takes the raw, asynchronous and bouncy coin-sensor lines from the coin slot, then synchronises, debounces and classifies each coin. It emits a one-cycle 2-bit coin code that drives vending_machine's `in` port. It also rejects invalid or disallowed coins, flags jams and keeps a running count of accepted coins.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required to qualify a coin insertion or a release (>=2)
JAM_CYCLES, 64, cycles a sensor may stay high after qualification before a jam is declared (> DEBOUNCE_CYCLES)
CNT_W, 8, width of accepted-coin counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
sense_a  input  1  raw sensor for coin type A (low value), asynchronous to clk
sense_b  input  1  raw sensor for coin type B (high value), asynchronous to clk
accept_en  input  1  1 = coins may be accepted; 0 = route every coin to reject
in_code  output  2  coin event to vending_machine `in`: 00 none, 01 coin A, 10 coin B; 11 never driven
reject  output  1  one-cycle pulse: coin diverted to return chute
jam  output  1  level: sensor stuck, held from jam detection until return to IDLE
coin_count  output  CNT_W  number of accepted coins, saturating

Behaviour:
- Reset (rst=0, asynchronous): in_code=00, reject=0, jam=0, coin_count=0, synchroniser flops=0, counters=0, state=RELEASE.
- Startup: after reset deassertion, both sensors must read low for DEBOUNCE_CYCLES before any coin is considered. A coin already in the slot during reset is never counted.
- Each sense line passes through a 2-flop synchroniser. The FSM sees only the synchronised pair pat={sb,sa}.
- All outputs are registered. in_code and reject are high for exactly one cycle per coin, and never both in the same cycle.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE, JAM.
  - IDLE: if pat != 00, capture pat, set cnt=0, go to DEBOUNCE.
  - DEBOUNCE: if pat != captured (including 00), go to IDLE with no output (glitch). Otherwise cnt++. On the edge where cnt==DEBOUNCE_CYCLES-1, decide the coin and go to HELD with cnt=0.
  - Decision, with accept_en sampled on the decision edge:
    - captured 01 and accept_en=1: in_code=01, coin_count++.
    - captured 10 and accept_en=1: in_code=10, coin_count++.
    - captured 11, or accept_en=0: reject=1, coin_count unchanged.
  - HELD: if pat==00, go to RELEASE with cnt=0. Otherwise cnt++. When cnt reaches JAM_CYCLES, go to JAM and set jam=1.
  - RELEASE: if pat != 00, go to HELD with cnt=0 (jam retained if already set). Otherwise cnt++. When cnt==DEBOUNCE_CYCLES-1, go to IDLE and clear jam.
  - JAM: jam=1. If pat==00, go to RELEASE with cnt=0.
- Latency: let edge t0 be the first edge at which the raw sense line is sampled high. For a stable coin, in_code or reject is valid in the cycle after edge t0+2+DEBOUNCE_CYCLES (t0+6 at default).
- Changes in accept_en outside the decision edge have no effect.
- coin_count saturates at 2^CNT_W-1 and never wraps.
- A pattern change during HELD (e.g. 01 to 11) does not produce a second event. Only one event is produced per insertion until the return to IDLE.
- Reset mid-operation aborts any pending decision: no pulse is emitted and the FSM restarts in RELEASE.

Test Plan:
1. Defaults, accept_en=1, sense_a high 12 cycles then low -> in_code=01 for exactly one cycle, 6 edges after the first sampling edge; reject=0; coin_count 0->1; FSM back in IDLE 4 cycles after sync'd release.
2. sense_b high for 2 cycles (glitch), and separately a 3-cycle high pulse -> in_code stays 00, reject stays 0, coin_count unchanged.
3. sense_a and sense_b both high 10 cycles -> reject=1 for one cycle, in_code stays 00, coin_count unchanged. Then a sense_b coin -> in_code=10, coin_count+1.
4. accept_en=0 at the decision edge with a sense_a coin -> reject pulse, no in_code. accept_en toggled 0->1 mid-HELD -> no late in_code.
5. sense_a held high 100 cycles -> single 01 pulse; jam=1 from cycle 64 of HELD; after release jam clears 4 cycles after sync'd low; the next coin is accepted normally.
6. rst pulled low mid-DEBOUNCE with sense_a held high through deassertion -> all outputs 0 immediately; no in_code until sense_a low for 4 cycles; a new insertion is then accepted. Separately, preset coin_count near max (CNT_W=2, 4 coins) -> count saturates at 3.
